// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the MIPS pipeline datapath and pipe_hazard_ctrl.
// The datapath side is master; the controller side is slave.
interface pipe_hazard_ctrl_if;
   logic [4:0] Rs_decode;
   logic [4:0] Rt_decode;
   logic [4:0] Rs_exe;
   logic [4:0] Rt_exe;
   logic [4:0] writereg_exe;
   logic [4:0] writereg_mem;
   logic [4:0] writereg_wb;
   logic       regwrite_exe;
   logic       regwrite_mem;
   logic       regwrite_wb;
   logic       memtoreg_exe;
   logic       memtoreg_mem;
   logic       branch_decode;
   logic       branch_taken_decode;
   logic       jump_decode;
   logic       muldiv_decode;
   logic       hilo_read_decode;
   logic       muldiv_start_exe;

   logic       stall_fetch;
   logic       stall_decode;
   logic       flush_decode;
   logic       flush_exe;
   logic [1:0] forwardA_exe;
   logic [1:0] forwardB_exe;
   logic       forwardA_decode;
   logic       forwardB_decode;
   logic       muldiv_busy;
   logic       muldiv_done;

   modport master (
      output Rs_decode, Rt_decode, Rs_exe, Rt_exe,
             writereg_exe, writereg_mem, writereg_wb,
             regwrite_exe, regwrite_mem, regwrite_wb,
             memtoreg_exe, memtoreg_mem,
             branch_decode, branch_taken_decode, jump_decode,
             muldiv_decode, hilo_read_decode, muldiv_start_exe,
      input  stall_fetch, stall_decode, flush_decode, flush_exe,
             forwardA_exe, forwardB_exe, forwardA_decode, forwardB_decode,
             muldiv_busy, muldiv_done
   );

   modport slave (
      input  Rs_decode, Rt_decode, Rs_exe, Rt_exe,
             writereg_exe, writereg_mem, writereg_wb,
             regwrite_exe, regwrite_mem, regwrite_wb,
             memtoreg_exe, memtoreg_mem,
             branch_decode, branch_taken_decode, jump_decode,
             muldiv_decode, hilo_read_decode, muldiv_start_exe,
      output stall_fetch, stall_decode, flush_decode, flush_exe,
             forwardA_exe, forwardB_exe, forwardA_decode, forwardB_decode,
             muldiv_busy, muldiv_done
   );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage MIPS pipeline: stalls, flushes,
// operand forwarding and a multi-cycle MUL/DIV busy sequencer guarding HI/LO readers.
module pipe_hazard_ctrl #(
   parameter int unsigned MULDIV_CYCLES = 32,
   parameter int unsigned CNT_W         = 8
) (
   input logic               clk,
   input logic               rst,
   pipe_hazard_ctrl_if.slave hz
);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_t;

   md_state_t        state;
   logic [CNT_W-1:0] cnt;
   logic             busy_q;
   logic             done_q;

   logic             lwstall;
   logic             brstall;
   logic             mdstall;
   logic             stall;

   // $0 is hard-wired, so a write to it is never a real dependency
   function automatic logic hit(input logic [4:0] dst, input logic [4:0] src);
      return (dst != 5'd0) && (dst == src);
   endfunction

   // MUL/DIV sequencer; busy/done are registered alongside the state
   always_ff @(posedge clk) begin
      if (!rst) begin
         state  <= IDLE;
         cnt    <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (hz.muldiv_start_exe) begin
                  state  <= BUSY;
                  cnt    <= CNT_LOAD;
                  busy_q <= 1'b1;
               end
            end
            BUSY: begin
               if (cnt == '0) begin
                  state  <= DONE;
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            DONE: begin
               done_q <= 1'b0;
               if (hz.muldiv_start_exe) begin
                  state  <= BUSY;
                  cnt    <= CNT_LOAD;
                  busy_q <= 1'b1;
               end else begin
                  state <= IDLE;
               end
            end
            default: begin
               state  <= IDLE;
               cnt    <= '0;
               busy_q <= 1'b0;
               done_q <= 1'b0;
            end
         endcase
      end
   end

   assign hz.muldiv_busy = busy_q;
   assign hz.muldiv_done = done_q;

   // Stall sources: load-use, branch operand not yet available in ID, HI/LO not committed
   always_comb begin
      lwstall = hz.memtoreg_exe &&
                (hit(hz.writereg_exe, hz.Rs_decode) || hit(hz.writereg_exe, hz.Rt_decode));
      brstall = hz.branch_decode &&
                ((hz.regwrite_exe &&
                  (hit(hz.writereg_exe, hz.Rs_decode) || hit(hz.writereg_exe, hz.Rt_decode))) ||
                 (hz.memtoreg_mem &&
                  (hit(hz.writereg_mem, hz.Rs_decode) || hit(hz.writereg_mem, hz.Rt_decode))));
      mdstall = (hz.muldiv_decode || hz.hilo_read_decode) &&
                ((state == BUSY) || hz.muldiv_start_exe);
      stall   = lwstall || brstall || mdstall;
   end

   // Control and forwarding outputs; reset forces a flushed, non-stalled pipeline
   always_comb begin
      hz.stall_fetch     = 1'b0;
      hz.stall_decode    = 1'b0;
      hz.flush_decode    = 1'b1;
      hz.flush_exe       = 1'b1;
      hz.forwardA_exe    = 2'b00;
      hz.forwardB_exe    = 2'b00;
      hz.forwardA_decode = 1'b0;
      hz.forwardB_decode = 1'b0;
      if (rst) begin
         hz.stall_fetch  = stall;
         hz.stall_decode = stall;
         hz.flush_exe    = stall;
         hz.flush_decode = (hz.branch_taken_decode || hz.jump_decode) && !stall;

         if (hz.regwrite_mem && hit(hz.writereg_mem, hz.Rs_exe))
            hz.forwardA_exe = 2'b10;
         else if (hz.regwrite_wb && hit(hz.writereg_wb, hz.Rs_exe))
            hz.forwardA_exe = 2'b01;

         if (hz.regwrite_mem && hit(hz.writereg_mem, hz.Rt_exe))
            hz.forwardB_exe = 2'b10;
         else if (hz.regwrite_wb && hit(hz.writereg_wb, hz.Rt_exe))
            hz.forwardB_exe = 2'b01;

         hz.forwardA_decode = hz.regwrite_mem && hit(hz.writereg_mem, hz.Rs_decode);
         hz.forwardB_decode = hz.regwrite_mem && hit(hz.writereg_mem, hz.Rt_decode);
      end
   end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed vectors push hand-computed
// expected output words; a negedge monitor pops and compares them.
module tb_pipe_hazard_ctrl;
   logic clk;
   logic rst;

   pipe_hazard_ctrl_if hz ();

   pipe_hazard_ctrl #(.MULDIV_CYCLES(4), .CNT_W(8)) dut (
      .clk (clk),
      .rst (rst),
      .hz  (hz.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   string       name_q[$];
   logic [11:0] exp_q[$];
   int          n_checks = 0;
   int          n_pass   = 0;

   // {stall_fetch, stall_decode, flush_decode, flush_exe, fA_exe, fB_exe, fA_dec, fB_dec, busy, done}
   function automatic logic [11:0] ov(input logic sf, input logic sd, input logic fd,
                                      input logic fe, input logic [1:0] fa, input logic [1:0] fb,
                                      input logic fad, input logic fbd,
                                      input logic busy, input logic done);
      return {sf, sd, fd, fe, fa, fb, fad, fbd, busy, done};
   endfunction

   function automatic logic [11:0] actual();
      return {hz.stall_fetch, hz.stall_decode, hz.flush_decode, hz.flush_exe,
              hz.forwardA_exe, hz.forwardB_exe, hz.forwardA_decode, hz.forwardB_decode,
              hz.muldiv_busy, hz.muldiv_done};
   endfunction

   // Monitor: compare everything queued for the current cycle
   always @(negedge clk) begin
      while (exp_q.size() > 0) begin
         string       nm;
         logic [11:0] ev;
         logic [11:0] av;
         nm = name_q.pop_front();
         ev = exp_q.pop_front();
         av = actual();
         n_checks++;
         if (av === ev) n_pass++;
         else $display("FAIL %s: got %b expected %b", nm, av, ev);
      end
   end

   task automatic clear_inputs();
      hz.Rs_decode = '0; hz.Rt_decode = '0; hz.Rs_exe = '0; hz.Rt_exe = '0;
      hz.writereg_exe = '0; hz.writereg_mem = '0; hz.writereg_wb = '0;
      hz.regwrite_exe = 1'b0; hz.regwrite_mem = 1'b0; hz.regwrite_wb = 1'b0;
      hz.memtoreg_exe = 1'b0; hz.memtoreg_mem = 1'b0;
      hz.branch_decode = 1'b0; hz.branch_taken_decode = 1'b0; hz.jump_decode = 1'b0;
      hz.muldiv_decode = 1'b0; hz.hilo_read_decode = 1'b0; hz.muldiv_start_exe = 1'b0;
   endtask

   // Queue the expectation for the cycle just driven, then advance to the next cycle
   task automatic step(input string nm, input logic [11:0] ev);
      name_q.push_back(nm);
      exp_q.push_back(ev);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b0;
      clear_inputs();
      repeat (2) @(posedge clk);
      #1;

      // Reset: forwarding and redirect inputs must be masked
      hz.regwrite_mem = 1'b1; hz.writereg_mem = 5'd5; hz.Rs_exe = 5'd5; hz.Rs_decode = 5'd5;
      hz.branch_taken_decode = 1'b1;
      step("reset", ov(0,0,1,1,2'b00,2'b00,0,0,0,0));

      rst = 1'b1;
      clear_inputs();
      step("idle", ov(0,0,0,0,2'b00,2'b00,0,0,0,0));

      // Load-use: lw $2 in EXE, add reads $2 in ID
      hz.memtoreg_exe = 1'b1; hz.regwrite_exe = 1'b1; hz.writereg_exe = 5'd2; hz.Rs_decode = 5'd2;
      step("lw_stall", ov(1,1,0,1,2'b00,2'b00,0,0,0,0));
      clear_inputs();
      hz.memtoreg_mem = 1'b1; hz.regwrite_mem = 1'b1; hz.writereg_mem = 5'd2; hz.Rs_decode = 5'd2;
      step("lw_in_mem", ov(0,0,0,0,2'b00,2'b00,1,0,0,0));
      clear_inputs();
      hz.regwrite_wb = 1'b1; hz.writereg_wb = 5'd2; hz.Rs_exe = 5'd2;
      step("lw_in_wb_fwd", ov(0,0,0,0,2'b01,2'b00,0,0,0,0));

      // Forwarding priority and $0
      clear_inputs();
      hz.regwrite_mem = 1'b1; hz.writereg_mem = 5'd5; hz.regwrite_wb = 1'b1; hz.writereg_wb = 5'd5;
      hz.Rs_exe = 5'd5; hz.Rt_exe = 5'd5;
      step("fwd_mem_pri", ov(0,0,0,0,2'b10,2'b10,0,0,0,0));
      hz.writereg_mem = 5'd0; hz.writereg_wb = 5'd0; hz.Rs_exe = 5'd0; hz.Rt_exe = 5'd0;
      step("fwd_r0", ov(0,0,0,0,2'b00,2'b00,0,0,0,0));
      hz.writereg_mem = 5'd7; hz.writereg_wb = 5'd9; hz.Rs_exe = 5'd7; hz.Rt_exe = 5'd9;
      step("fwd_split", ov(0,0,0,0,2'b10,2'b01,0,0,0,0));
      hz.regwrite_mem = 1'b0; hz.regwrite_wb = 1'b0;
      step("fwd_no_we", ov(0,0,0,0,2'b00,2'b00,0,0,0,0));
      clear_inputs();
      hz.memtoreg_exe = 1'b1; hz.writereg_exe = 5'd0; hz.Rt_decode = 5'd0;
      step("lw_r0_nostall", ov(0,0,0,0,2'b00,2'b00,0,0,0,0));

      // Branch operand hazards and redirect
      clear_inputs();
      hz.branch_decode = 1'b1; hz.branch_taken_decode = 1'b1; hz.Rs_decode = 5'd3;
      hz.regwrite_exe = 1'b1; hz.writereg_exe = 5'd3;
      step("br_stall_exe", ov(1,1,0,1,2'b00,2'b00,0,0,0,0));
      hz.regwrite_exe = 1'b0; hz.writereg_exe = 5'd0;
      hz.regwrite_mem = 1'b1; hz.writereg_mem = 5'd3;
      step("br_fwd_mem", ov(0,0,1,0,2'b00,2'b00,1,0,0,0));
      clear_inputs();
      hz.branch_decode = 1'b1; hz.Rt_decode = 5'd4;
      hz.memtoreg_mem = 1'b1; hz.regwrite_mem = 1'b1; hz.writereg_mem = 5'd4;
      step("br_stall_load_mem", ov(1,1,0,1,2'b00,2'b00,0,1,0,0));
      clear_inputs();
      hz.jump_decode = 1'b1;
      step("jump_flush", ov(0,0,1,0,2'b00,2'b00,0,0,0,0));

      // MUL/DIV with an mfhi waiting in ID
      clear_inputs();
      hz.muldiv_start_exe = 1'b1; hz.hilo_read_decode = 1'b1;
      step("md_c0", ov(1,1,0,1,2'b00,2'b00,0,0,0,0));
      hz.muldiv_start_exe = 1'b0;
      for (int i = 1; i <= 4; i++) step($sformatf("md_busy_c%0d", i), ov(1,1,0,1,2'b00,2'b00,0,0,1,0));
      step("md_done_c5", ov(0,0,0,0,2'b00,2'b00,0,0,0,1));
      hz.hilo_read_decode = 1'b0;
      step("md_idle_c6", ov(0,0,0,0,2'b00,2'b00,0,0,0,0));

      // Back-to-back operations: restart during DONE
      hz.muldiv_start_exe = 1'b1;
      step("b2b_c0", ov(0,0,0,0,2'b00,2'b00,0,0,0,0));
      hz.muldiv_start_exe = 1'b0;
      for (int i = 1; i <= 4; i++) step($sformatf("b2b_busy1_c%0d", i), ov(0,0,0,0,2'b00,2'b00,0,0,1,0));
      hz.muldiv_start_exe = 1'b1;
      step("b2b_done1", ov(0,0,0,0,2'b00,2'b00,0,0,0,1));
      hz.muldiv_start_exe = 1'b0;
      for (int i = 1; i <= 4; i++) step($sformatf("b2b_busy2_c%0d", i), ov(0,0,0,0,2'b00,2'b00,0,0,1,0));
      step("b2b_done2", ov(0,0,0,0,2'b00,2'b00,0,0,0,1));
      step("b2b_idle", ov(0,0,0,0,2'b00,2'b00,0,0,0,0));

      // Reset in the middle of BUSY
      hz.muldiv_start_exe = 1'b1;
      step("rstmid_start", ov(0,0,0,0,2'b00,2'b00,0,0,0,0));
      hz.muldiv_start_exe = 1'b0;
      step("rstmid_busy1", ov(0,0,0,0,2'b00,2'b00,0,0,1,0));
      hz.hilo_read_decode = 1'b1;
      step("rstmid_busy2", ov(1,1,0,1,2'b00,2'b00,0,0,1,0));
      rst = 1'b0;
      step("rstmid_low", ov(0,0,1,1,2'b00,2'b00,0,0,1,0));
      step("rstmid_cleared", ov(0,0,1,1,2'b00,2'b00,0,0,0,0));
      rst = 1'b1;
      step("rstmid_idle", ov(0,0,0,0,2'b00,2'b00,0,0,0,0));

      @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
         n_checks++;
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Hazard and sequencing controller for the 5-stage MIPS pipeline.
- Drives the stall inputs of the IF and ID stages, and the flush inputs of the IF/ID and ID/EX pipeline registers (flush_exe).
- Generates operand-forwarding selects for the EXE stage and the ID-stage branch comparator.
- Owns a multi-cycle MUL/DIV busy sequencer that blocks HI/LO consumers until the result is committed.

Parameters:
- MULDIV_CYCLES, 32, cycles spent in BUSY per mult/div operation; legal range 1 to 255.
- CNT_W, 8, counter width; must satisfy 2^CNT_W > MULDIV_CYCLES.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-low.
- Rs_decode, Rt_decode  input  5 each  source registers of the instruction in ID.
- Rs_exe, Rt_exe  input  5 each  source registers of the instruction in EXE.
- writereg_exe, writereg_mem, writereg_wb  input  5 each  destination register per stage.
- regwrite_exe, regwrite_mem, regwrite_wb  input  1 each  register-write enable per stage.
- memtoreg_exe, memtoreg_mem  input  1 each  the stage holds a load.
- branch_decode  input  1  conditional branch in ID.
- branch_taken_decode  input  1  branch resolved taken in ID.
- jump_decode  input  1  jump in ID.
- muldiv_decode  input  1  mult/div in ID.
- hilo_read_decode  input  1  mfhi/mflo in ID.
- muldiv_start_exe  input  1  mult/div in EXE this cycle.
- stall_fetch, stall_decode  output  1 each  hold the PC and IF/ID register.
- flush_decode  output  1  clear IF/ID.
- flush_exe  output  1  clear ID/EX (insert bubble).
- forwardA_exe, forwardB_exe  output  2 each  00 = ID/EX data, 01 = WB result, 10 = MEM ALU result.
- forwardA_decode, forwardB_decode  output  1 each  select the MEM ALU result for the branch comparator.
- muldiv_busy  output  1  sequencer is in BUSY.
- muldiv_done  output  1  one-cycle pulse; HI/LO commit at the end of this cycle.

Behaviour:
- Register $0 never matches: no forwarding and no stall on index 0.
- Forwarding (combinational), shown for A; B is identical using Rt_exe / Rt_decode:
  - forwardA_exe = 10 if regwrite_mem && writereg_mem == Rs_exe.
  - Else 01 if regwrite_wb && writereg_wb == Rs_exe.
  - Else 00. MEM always has priority over WB.
  - forwardA_decode = regwrite_mem && writereg_mem == Rs_decode.
- lwstall = memtoreg_exe && writereg_exe ∈ {Rs_decode, Rt_decode}.
- brstall = branch_decode && ((regwrite_exe && writereg_exe ∈ {Rs_decode, Rt_decode}) || (memtoreg_mem && writereg_mem ∈ {Rs_decode, Rt_decode})).
- mdstall = (muldiv_decode || hilo_read_decode) && (state == BUSY || muldiv_start_exe).
- stall = lwstall | brstall | mdstall.
- stall_fetch = stall_decode = flush_exe = stall.
- flush_decode = (branch_taken_decode | jump_decode) && !stall. When a stall and a redirect coincide, the stall wins and the redirect is re-evaluated after the stall clears.
- Sequencer (registered): states IDLE, BUSY, DONE; counter cnt[CNT_W-1:0].
  - IDLE: if muldiv_start_exe, go to BUSY and load cnt = MULDIV_CYCLES-1.
  - BUSY: if cnt == 0 go to DONE, else decrement cnt. A muldiv_start_exe in BUSY is impossible by construction (mdstall) and is ignored.
  - DONE: if muldiv_start_exe, go to BUSY and reload cnt (back-to-back ops); else go to IDLE.
- muldiv_busy = (state == BUSY); muldiv_done = (state == DONE). Both are registered, with no glitches.
- Latency: start seen in cycle t gives muldiv_busy high for cycles t+1 through t+MULDIV_CYCLES, and muldiv_done at t+MULDIV_CYCLES+1.
- Reset (rst == 0 at posedge clk, including mid-operation): state = IDLE, cnt = 0, muldiv_busy = 0, muldiv_done = 0.
- While rst is low, all combinational outputs are forced as follows:
  - stall_fetch = 0, stall_decode = 0, flush_decode = 1, flush_exe = 1.
  - All forward selects = 0.

Test Plan:
- lw $2 in EXE (memtoreg_exe = 1, writereg_exe = 2) with add using Rs_decode = 2 -> stall_fetch, stall_decode and flush_exe all 1 for exactly one cycle; add then sees forwardA_exe = 01 when lw reaches WB.
- regwrite_mem = 1, writereg_mem = 5; regwrite_wb = 1, writereg_wb = 5; Rs_exe = 5 -> forwardA_exe = 10. Repeat with writereg = 0 -> forwardA_exe = 00.
- beq Rs_decode = 3 with regwrite_exe = 1, writereg_exe = 3, branch_taken_decode = 1 -> stall = 1 and flush_decode = 0. Next cycle (producer in MEM): forwardA_decode = 1, stall = 0, flush_decode = 1.
- MULDIV_CYCLES = 4: muldiv_start_exe pulse at cycle 0 -> muldiv_busy high in cycles 1–4, muldiv_done high in cycle 5. hilo_read_decode held from cycle 0 -> stall in cycles 0–4, released in cycle 5.
- Back-to-back: second muldiv_start_exe during DONE -> re-enters BUSY with no IDLE cycle; muldiv_done pulses once per operation.
- rst driven low in the middle of BUSY -> next edge gives IDLE with muldiv_busy = 0; flush_exe = 1 and stall = 0 while rst is low.
